// File: rtl/wb_regfile.sv
// Writeback register file with zero-latency reads, same-cycle write bypass
// and per-register busy (scoreboard) tracking for decode-stage hazard stalls.
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ASIZE
`define ASIZE 5
`endif

module wb_regfile #(
    parameter int DSIZE = `DSIZE,
    parameter int ASIZE = `ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    input  logic             issue,
    input  logic [ASIZE-1:0] issue_waddr,
    output logic             busy1,
    output logic             busy2,
    output logic             stall,
    output logic [ASIZE:0]   pending_cnt
);

    localparam int NREG = 2 ** ASIZE;

    logic [DSIZE-1:0] regs_q [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [ASIZE:0]   cnt_q, cnt_d;
    logic             wr_v, iss_v, cnt_inc, cnt_dec;

    assign wr_v  = wen && (waddr != '0);
    assign iss_v = issue && (issue_waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_v) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Clear first, then set, so a same-register set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wr_v)  busy_d[waddr]       = 1'b0;
        if (iss_v) busy_d[issue_waddr] = 1'b1;
    end

    // Count only actual bit transitions so the counter equals popcount(busy).
    always_comb begin
        cnt_inc = iss_v && !busy_q[issue_waddr];
        cnt_dec = wr_v && busy_q[waddr] && !(iss_v && (issue_waddr == waddr));
        cnt_d   = cnt_q + (ASIZE+1)'(cnt_inc) - (ASIZE+1)'(cnt_dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            if (wr_v && (waddr == raddr1)) rdata1 = wdata;
            else                           rdata1 = regs_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            if (wr_v && (waddr == raddr2)) rdata2 = wdata;
            else                           rdata2 = regs_q[raddr2];
        end
    end

    // A same-cycle writeback is bypassed, so the operand is no longer busy.
    assign busy1 = busy_q[raddr1] && (raddr1 != '0) && !(wen && (waddr == raddr1));
    assign busy2 = busy_q[raddr2] && (raddr2 != '0) && !(wen && (waddr == raddr2));
    assign stall = busy1 | busy2;
    assign pending_cnt = cnt_q;

endmodule
